// File: rtl/cvxif_issue_master.sv
// Core-side CV-X-IF initiator: issues one offload candidate at a time, commits it, tracks
// writeback instructions in a small scoreboard and returns their results to the core.
module cvxif_issue_master #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NrOutstanding = 4,
    parameter int unsigned IdBits        = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic              x_issue_valid_o,
    input  logic              x_issue_ready_i,
    output logic [31:0]       x_issue_instr_o,
    output logic [IdBits-1:0] x_issue_id_o,
    output logic [XLEN-1:0]   x_issue_rs1_o,
    output logic [XLEN-1:0]   x_issue_rs2_o,
    input  logic              x_resp_accept_i,
    input  logic              x_resp_writeback_i,
    output logic              x_commit_valid_o,
    output logic [IdBits-1:0] x_commit_id_o,
    output logic              x_commit_kill_o,
    input  logic              x_result_valid_i,
    output logic              x_result_ready_o,
    input  logic [IdBits-1:0] x_result_id_i,
    input  logic [XLEN-1:0]   x_result_data_i,
    input  logic [4:0]        x_result_rd_i,
    input  logic              x_result_we_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              illegal_o,
    output logic [31:0]       illegal_tval_o,
    output logic              id_err_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

    state_e                   state_q, state_d;
    logic [NrOutstanding-1:0] pending_q, pending_d;
    logic [31:0]              instr_q;
    logic [XLEN-1:0]          rs1_q, rs2_q;
    logic [IdBits-1:0]        id_q;
    logic                     kill_q;
    logic                     illegal_q;
    logic [31:0]              tval_q;
    logic                     wb_valid_q;
    logic [4:0]               wb_rd_q;
    logic [XLEN-1:0]          wb_data_q;
    logic                     id_err_q;

    logic [IdBits-1:0] free_id;
    logic              any_free;
    logic              take;
    logic              issue_hs;
    logic              res_hit;

    // Lowest-index free entry; only registered pending state is used, so an entry freed by a
    // result this cycle becomes allocatable one cycle later.
    always_comb begin
        free_id  = '0;
        any_free = 1'b0;
        for (int i = NrOutstanding - 1; i >= 0; i--) begin
            if (!pending_q[i]) begin
                free_id  = IdBits'(i);
                any_free = 1'b1;
            end
        end
    end

    assign instr_ready_o = (state_q == StIdle) & any_free & ~flush_i & ~rst_i;
    assign take          = instr_valid_i & instr_ready_o;
    assign issue_hs      = (state_q == StIssue) & x_issue_ready_i;
    assign res_hit       = x_result_valid_i & pending_q[x_result_id_i];

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (res_hit) begin
            pending_d[x_result_id_i] = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (issue_hs) begin
                    state_d = x_resp_accept_i ? StCommit : StIdle;
                    if (x_resp_accept_i && x_resp_writeback_i && !flush_i) begin
                        pending_d[id_q] = 1'b1;
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (flush_i) begin
                    pending_d[id_q] = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            id_q       <= '0;
            kill_q     <= 1'b0;
            illegal_q  <= 1'b0;
            tval_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            id_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (take) begin
                instr_q <= instr_i;
                rs1_q   <= rs1_i;
                rs2_q   <= rs2_i;
                id_q    <= free_id;
            end
            if (issue_hs) begin
                kill_q <= flush_i;
            end
            illegal_q <= issue_hs & ~x_resp_accept_i;
            if (issue_hs && !x_resp_accept_i) begin
                tval_q <= instr_q;
            end
            wb_valid_q <= res_hit & x_result_we_i;
            if (res_hit) begin
                wb_rd_q   <= x_result_rd_i;
                wb_data_q <= x_result_data_i;
            end
            id_err_q <= x_result_valid_i & ~pending_q[x_result_id_i];
        end
    end

    assign x_issue_valid_o  = (state_q == StIssue);
    assign x_issue_instr_o  = instr_q;
    assign x_issue_id_o     = id_q;
    assign x_issue_rs1_o    = rs1_q;
    assign x_issue_rs2_o    = rs2_q;
    assign x_commit_valid_o = (state_q == StCommit);
    assign x_commit_id_o    = id_q;
    // A flush seen at the handshake or during the commit cycle itself kills the instruction.
    assign x_commit_kill_o  = (state_q == StCommit) & (kill_q | flush_i);
    assign x_result_ready_o = 1'b1;
    assign wb_valid_o       = wb_valid_q;
    assign wb_rd_o          = wb_rd_q;
    assign wb_data_o        = wb_data_q;
    assign illegal_o        = illegal_q;
    assign illegal_tval_o   = tval_q;
    assign id_err_o         = id_err_q;

endmodule

// File: tb/tb_cvxif_issue_master.sv
// Self-checking bench for cvxif_issue_master: table-driven issue vectors plus hand-written
// result, full-scoreboard, flush and reset sequences, checked through an expectation queue.
module tb_cvxif_issue_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_i, rs2_i;
    logic        x_issue_valid_o;
    logic        x_issue_ready_i;
    logic [31:0] x_issue_instr_o;
    logic [1:0]  x_issue_id_o;
    logic [31:0] x_issue_rs1_o, x_issue_rs2_o;
    logic        x_resp_accept_i, x_resp_writeback_i;
    logic        x_commit_valid_o;
    logic [1:0]  x_commit_id_o;
    logic        x_commit_kill_o;
    logic        x_result_valid_i;
    logic        x_result_ready_o;
    logic [1:0]  x_result_id_i;
    logic [31:0] x_result_data_i;
    logic [4:0]  x_result_rd_i;
    logic        x_result_we_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        illegal_o;
    logic [31:0] illegal_tval_o;
    logic        id_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    cvxif_issue_master #(
        .XLEN         (32),
        .NrOutstanding(4),
        .IdBits       (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .instr_valid_i     (instr_valid_i),
        .instr_ready_o     (instr_ready_o),
        .instr_i           (instr_i),
        .rs1_i             (rs1_i),
        .rs2_i             (rs2_i),
        .x_issue_valid_o   (x_issue_valid_o),
        .x_issue_ready_i   (x_issue_ready_i),
        .x_issue_instr_o   (x_issue_instr_o),
        .x_issue_id_o      (x_issue_id_o),
        .x_issue_rs1_o     (x_issue_rs1_o),
        .x_issue_rs2_o     (x_issue_rs2_o),
        .x_resp_accept_i   (x_resp_accept_i),
        .x_resp_writeback_i(x_resp_writeback_i),
        .x_commit_valid_o  (x_commit_valid_o),
        .x_commit_id_o     (x_commit_id_o),
        .x_commit_kill_o   (x_commit_kill_o),
        .x_result_valid_i  (x_result_valid_i),
        .x_result_ready_o  (x_result_ready_o),
        .x_result_id_i     (x_result_id_i),
        .x_result_data_i   (x_result_data_i),
        .x_result_rd_i     (x_result_rd_i),
        .x_result_we_i     (x_result_we_i),
        .wb_valid_o        (wb_valid_o),
        .wb_rd_o           (wb_rd_o),
        .wb_data_o         (wb_data_o),
        .illegal_o         (illegal_o),
        .illegal_tval_o    (illegal_tval_o),
        .id_err_o          (id_err_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        accept;
        logic        wb;
        logic        flush;
        int          stall;
        logic [1:0]  exp_id;
        logic        exp_commit;
        logic        exp_kill;
    } vec_t;

    typedef struct {
        logic        commit;
        logic        kill;
        logic [1:0]  id;
        logic [31:0] tval;
        logic        wbv;
        logic        err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: expectation queue empty");
            e = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0};
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic do_issue(input vec_t v);
        exp_t e;
        bit   got;
        instr_valid_i = 1'b1;
        instr_i       = v.instr;
        rs1_i         = v.rs1;
        rs2_i         = v.rs2;
        got           = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (instr_ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL instr_ready timeout for instr 0x%08h", v.instr);
            instr_valid_i = 1'b0;
        end else begin
            @(negedge clk_i);
            instr_valid_i = 1'b0;
            instr_i       = '0;
            rs1_i         = '0;
            rs2_i         = '0;
            #1;
            check("issue_valid", 32'(x_issue_valid_o), 32'd1);
            check("issue_id", 32'(x_issue_id_o), 32'(v.exp_id));
            check("issue_instr", x_issue_instr_o, v.instr);
            check("issue_rs1", x_issue_rs1_o, v.rs1);
            check("issue_rs2", x_issue_rs2_o, v.rs2);
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk_i);
                #1;
                check("stall_valid", 32'(x_issue_valid_o), 32'd1);
                check("stall_instr", x_issue_instr_o, v.instr);
                check("stall_id", 32'(x_issue_id_o), 32'(v.exp_id));
            end
            x_issue_ready_i    = 1'b1;
            x_resp_accept_i    = v.accept;
            x_resp_writeback_i = v.wb;
            flush_i            = v.flush;
            exp_q.push_back('{v.exp_commit, v.exp_kill, v.exp_id, v.instr,
                              1'b0, 1'b0, 5'd0, 32'd0});
            @(negedge clk_i);
            x_issue_ready_i    = 1'b0;
            x_resp_accept_i    = 1'b0;
            x_resp_writeback_i = 1'b0;
            flush_i            = 1'b0;
            #1;
            pop_exp(e);
            check("commit_valid", 32'(x_commit_valid_o), 32'(e.commit));
            check("illegal", 32'(illegal_o), 32'(!e.commit));
            if (e.commit) begin
                check("commit_id", 32'(x_commit_id_o), 32'(e.id));
                check("commit_kill", 32'(x_commit_kill_o), 32'(e.kill));
            end else begin
                check("illegal_tval", illegal_tval_o, e.tval);
            end
            check("issue_valid_after", 32'(x_issue_valid_o), 32'd0);
            check("no_wb_on_commit", 32'(wb_valid_o), 32'd0);
            @(negedge clk_i);
            #1;
            check("commit_one_cycle", 32'(x_commit_valid_o), 32'd0);
            check("illegal_one_cycle", 32'(illegal_o), 32'd0);
        end
    endtask

    task automatic send_result(input logic [1:0] id, input logic [4:0] rd,
                               input logic [31:0] data, input logic we,
                               input logic exp_hit);
        exp_t e;
        x_result_valid_i = 1'b1;
        x_result_id_i    = id;
        x_result_rd_i    = rd;
        x_result_data_i  = data;
        x_result_we_i    = we;
        exp_q.push_back('{1'b0, 1'b0, id, 32'd0, exp_hit & we, ~exp_hit, rd, data});
        @(negedge clk_i);
        x_result_valid_i = 1'b0;
        x_result_we_i    = 1'b0;
        #1;
        pop_exp(e);
        check("wb_valid", 32'(wb_valid_o), 32'(e.wbv));
        check("id_err", 32'(id_err_o), 32'(e.err));
        if (!e.err) begin
            check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
            check("wb_data", wb_data_o, e.data);
        end
        @(negedge clk_i);
        #1;
        check("wb_one_cycle", 32'(wb_valid_o), 32'd0);
        check("id_err_one_cycle", 32'(id_err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        tbl[0] = '{32'h0000002B, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0, 0, 2'd0, 1'b1, 1'b0};
        tbl[1] = '{32'h00000033, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0, 2, 2'd0, 1'b0, 1'b0};
        tbl[2] = '{32'h00000043, 32'h55, 32'h66, 1'b0, 1'b1, 1'b0, 0, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000005B, 32'hA0, 32'hB0, 1'b1, 1'b1, 1'b0, 0, 2'd0, 1'b1, 1'b0};
        tbl[4] = '{32'h0000010B, 32'hA1, 32'hB1, 1'b1, 1'b1, 1'b0, 1, 2'd1, 1'b1, 1'b0};
        tbl[5] = '{32'h0000020B, 32'hA2, 32'hB2, 1'b1, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b0};
        tbl[6] = '{32'h0000030B, 32'hA3, 32'hB3, 1'b1, 1'b1, 1'b0, 0, 2'd3, 1'b1, 1'b0};

        rst_i              = 1'b1;
        flush_i            = 1'b0;
        instr_valid_i      = 1'b0;
        instr_i            = '0;
        rs1_i              = '0;
        rs2_i              = '0;
        x_issue_ready_i    = 1'b0;
        x_resp_accept_i    = 1'b0;
        x_resp_writeback_i = 1'b0;
        x_result_valid_i   = 1'b0;
        x_result_id_i      = '0;
        x_result_data_i    = '0;
        x_result_rd_i      = '0;
        x_result_we_i      = 1'b0;

        repeat (3) @(negedge clk_i);
        #1;
        check("rst_issue_valid", 32'(x_issue_valid_o), 32'd0);
        check("rst_commit_valid", 32'(x_commit_valid_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);
        check("rst_id_err", 32'(id_err_o), 32'd0);
        check("rst_instr_ready", 32'(instr_ready_o), 32'd0);
        check("rst_issue_instr", x_issue_instr_o, 32'd0);
        check("result_ready", 32'(x_result_ready_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("instr_ready_after_rst", 32'(instr_ready_o), 32'd1);
        @(negedge clk_i);

        // Result for a free entry must be rejected as an ID error.
        send_result(2'd3, 5'd9, 32'h12345678, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            do_issue(tbl[i]);
        end

        // Scoreboard now full: a waiting candidate must not be taken.
        @(negedge clk_i);
        instr_valid_i = 1'b1;
        instr_i       = 32'h0000040B;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            check("full_instr_ready", 32'(instr_ready_o), 32'd0);
            check("full_no_issue", 32'(x_issue_valid_o), 32'd0);
        end
        instr_valid_i = 1'b0;

        @(negedge clk_i);
        send_result(2'd2, 5'd7, 32'h22222222, 1'b1, 1'b1);
        @(negedge clk_i);
        v = '{32'h0000107B, 32'hC0, 32'hD0, 1'b1, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b0};
        do_issue(v);

        repeat (3) @(negedge clk_i);
        send_result(2'd0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1);

        // Flush in the handshake cycle: killed commit, entry never marked.
        @(negedge clk_i);
        v = '{32'h0000207B, 32'hC1, 32'hD1, 1'b1, 1'b1, 1'b1, 0, 2'd0, 1'b1, 1'b1};
        do_issue(v);
        @(negedge clk_i);
        send_result(2'd0, 5'd6, 32'h66666666, 1'b1, 1'b0);

        @(negedge clk_i);
        send_result(2'd1, 5'd12, 32'h0BADF00D, 1'b0, 1'b1);
        @(negedge clk_i);
        send_result(2'd1, 5'd12, 32'h0BADF00D, 1'b1, 1'b0);

        // Reset while an issue request is outstanding.
        @(negedge clk_i);
        instr_valid_i = 1'b1;
        instr_i       = 32'h0000307B;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        #1;
        check("pre_rst_issue_valid", 32'(x_issue_valid_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("midrst_issue_valid", 32'(x_issue_valid_o), 32'd0);
        check("midrst_commit_valid", 32'(x_commit_valid_o), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("midrst_issue_instr", x_issue_instr_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("post_rst_commit", 32'(x_commit_valid_o), 32'd0);
        check("post_rst_ready", 32'(instr_ready_o), 32'd1);
        send_result(2'd3, 5'd1, 32'h1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
